ng_out_dsky: RTL and testbench
==============================

Name: ng_out_dsky

Overview:
- Output-direction counterpart of the keypad input port.
- The AGC writes display relay words on the output channel. The block buffers them in a small FIFO, decodes each word into relay address, flag and two digit codes, and presents them to the external DSKY display controller over a four-phase DispReq/DispAck handshake.
- DispAck comes from an external domain. It is synchronised to CLK2 with a 3-bit shift register.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TIMEOUT, 1024: CLK2 cycles allowed per handshake phase before the word is abandoned.
- HOLD_CYC, 8: idle gap in CLK2 cycles between consecutive handshakes.

Ports:
- CLK2  in  1  AGC main clock; all logic on its rising edge.
- RST  in  1  Synchronous reset, active-high.
- OUT_WR  in  1  Single-cycle write strobe from the AGC output channel.
- OUT_BUS  in  16  Relay word. [15] ignored, [14:11] relay address, [10] flag, [9:5] digit A, [4:0] digit B.
- OUT_FULL  out  1  FIFO full, registered.
- DispReq  out  1  Request to display controller.
- DispAck  in  1  Acknowledge from display controller; asynchronous.
- DispAddr  out  4  Relay address of the presented word.
- DispFlag  out  1  Flag bit of the presented word.
- DispDigA  out  5  Digit A code.
- DispDigB  out  5  Digit B code.
- DispErr  out  1  Sticky handshake-timeout flag.
- DispOvf  out  1  Sticky write-dropped-while-full flag.

Behaviour:
- Reset (RST high at a clock edge):
  - FIFO empty; state IDLE.
  - All outputs 0.
  - Ack shift register cleared.
  - Timeout and hold counters cleared.
  - Reset mid-handshake aborts immediately, with DispReq 0 the next cycle and no data retained.
- Write:
  - OUT_WR=1 with OUT_BUS[14:11]!=0 enqueues OUT_BUS[14:0].
  - Address 0 is a no-op word: it is discarded and never enqueued, and DispOvf is unaffected.
  - Fullness is judged on the count at the start of the cycle. A write while full is dropped and sets DispOvf, even if a pop occurs in the same cycle.
  - A simultaneous write and pop while not full are both honoured; the count is unchanged.
- Ack sync:
  - AckSr <= {AckSr[1:0], DispAck} every cycle.
  - AckHi = AckSr[1].
  - AckRise = (AckSr[2:1]==2'b01). AckRise is unused; reserved for debug visibility.
- FSM states: IDLE, REQ, REL, HOLD.
  - IDLE:
    - If the FIFO is non-empty: pop the head, load the Disp* data registers, DispReq<=1, clear the timeout counter, go to REQ.
    - Latency: OUT_WR at edge N into an empty FIFO gives DispReq=1 and valid data after edge N+2.
  - REQ:
    - Wait for AckHi=1, then DispReq<=0 and go to REL.
    - If the timeout counter reaches TIMEOUT-1 first: DispReq<=0, DispErr<=1, go to HOLD. The word is lost.
  - REL:
    - Wait for AckHi=0, then go to HOLD.
    - Timeout as in REQ: DispErr<=1, go to HOLD.
  - HOLD:
    - Count HOLD_CYC cycles, then go to IDLE.
    - No new request may be issued before the count completes.
- Data registers change only on the IDLE->REQ load. They are stable throughout REQ, REL and HOLD.
- DispReq never rises while AckHi=1. If AckHi is still 1 in IDLE, the block waits in IDLE.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1. OUT_FULL = (count==DEPTH), updated the cycle after the change.
- DispErr and DispOvf clear only on RST.

Decomposition:
- Package ng_out_pkg:
  - field position constants (ADDR_MSB/LSB, FLAG_BIT, DIGA_MSB/LSB, DIGB_MSB/LSB);
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, REL=2'd2, HOLD=2'd3;
  - relay-word width constant (15).
- One sub-module: ng_sync_fifo. It is a parameterised width/depth register FIFO with wr, rd, full, empty and count, and is reusable for other output channels.
- FSM, ack synchroniser and decode stay in ng_out_dsky.

Test Plan:
- Reset then single write of 16'h5A53 (addr 4'hB, flag 0, digA 5'h12, digB 5'h13):
  - DispReq=1 two edges after the write, with DispAddr=4'hB, DispDigA=5'h12, DispDigB=5'h13.
  - Ack rise/fall completes the transfer; a 2nd word is not requested before HOLD_CYC elapses.
- Five back-to-back writes with DEPTH=4 and ack held low:
  - OUT_FULL=1 after the 4th; 5th is dropped and DispOvf=1.
  - Acking all transfers returns the four words in write order.
- Write with OUT_BUS[14:11]=0 (e.g. 16'h07FF):
  - FIFO stays empty, DispReq stays 0, DispOvf stays 0.
- Never assert DispAck:
  - DispReq drops after TIMEOUT cycles and DispErr=1.
  - The next queued word is then requested normally after HOLD_CYC.
- Assert RST during REQ with 2 words queued:
  - Next cycle DispReq=0, OUT_FULL=0, all data outputs 0.
  - No request follows.
- Write while full in the same cycle that IDLE pops:
  - Write dropped, DispOvf=1, count decreases by 1.

Source files
------------

// File: rtl/ng_out_pkg.sv
// ng_out_pkg: relay word field positions and display handshake state encoding.
package ng_out_pkg;
  localparam int WORD_W   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 11;
  localparam int FLAG_BIT = 10;
  localparam int DIGA_MSB = 9;
  localparam int DIGA_LSB = 5;
  localparam int DIGB_MSB = 4;
  localparam int DIGB_LSB = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2, HOLD = 2'd3} state_t;
endpackage

// File: rtl/ng_sync_fifo.sv
// ng_sync_fifo: register FIFO with registered full flag and occupancy count.
module ng_sync_fifo #(
  parameter int W = 15,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d, push, pop;
  // Fullness is the state at the start of the cycle, so a concurrent pop never frees a slot for this write.
  always_comb begin
    push = wr && !full_q;
    pop = rd && cnt_q != '0;
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    full_d = cnt_d == CW'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
  assign dout = mem_q[rp_q];
  assign full = full_q;
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/ng_out_dsky.sv
// ng_out_dsky: buffers AGC relay words and presents them to the DSKY over a DispReq/DispAck handshake.
module ng_out_dsky
  import ng_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1024,
  parameter int HOLD_CYC = 8
) (
  input  logic        CLK2,
  input  logic        RST,
  input  logic        OUT_WR,
  input  logic [15:0] OUT_BUS,
  output logic        OUT_FULL,
  output logic        DispReq,
  input  logic        DispAck,
  output logic [3:0]  DispAddr,
  output logic        DispFlag,
  output logic [4:0]  DispDigA,
  output logic [4:0]  DispDigB,
  output logic        DispErr,
  output logic        DispOvf
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t st_q, st_d;
  logic [2:0] ack_sr_q;
  logic ack_hi, ack_rise, avail_q;
  logic req_q, req_d, err_q, err_d, ovf_q, ovf_d;
  logic [WORD_W-1:0] word_q, word_d, fifo_dout;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic wr_en, rd_en, fifo_full, fifo_empty, tmo_done;
  logic [CW-1:0] fifo_count;
  logic unused_sig;
  assign ack_hi = ack_sr_q[1];
  assign ack_rise = ack_sr_q[2:1] == 2'b01;
  assign unused_sig = &{1'b0, ack_rise, OUT_BUS[15], fifo_count};
  assign wr_en = OUT_WR && OUT_BUS[ADDR_MSB:ADDR_LSB] != '0;
  assign tmo_done = tmo_q == TW'(TIMEOUT - 1);
  ng_sync_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK2), .rst(RST), .wr(wr_en), .rd(rd_en), .din(OUT_BUS[WORD_W-1:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  always_comb begin
    st_d = st_q;
    req_d = req_q;
    word_d = word_q;
    err_d = err_q;
    ovf_d = ovf_q | (wr_en && fifo_full);
    tmo_d = tmo_q;
    hold_d = hold_q;
    rd_en = 1'b0;
    case (st_q)
      IDLE: if (avail_q && !fifo_empty && !ack_hi) begin
        rd_en = 1'b1;
        word_d = fifo_dout;
        req_d = 1'b1;
        tmo_d = '0;
        st_d = REQ;
      end
      REQ: if (ack_hi) begin
        req_d = 1'b0;
        tmo_d = '0;
        st_d = REL;
      end else if (tmo_done) begin
        req_d = 1'b0;
        err_d = 1'b1;
        hold_d = '0;
        st_d = HOLD;
      end else tmo_d = tmo_q + TW'(1);
      REL: if (!ack_hi || tmo_done) begin
        err_d = err_q | ack_hi;
        hold_d = '0;
        st_d = HOLD;
      end else tmo_d = tmo_q + TW'(1);
      default: if (hold_q == HW'(HOLD_CYC - 1)) st_d = IDLE;
        else hold_d = hold_q + HW'(1);
    endcase
  end
  // avail_q re-registers FIFO occupancy so a fresh word reaches the display two edges after its write.
  always_ff @(posedge CLK2) begin
    if (RST) begin
      st_q <= IDLE;
      ack_sr_q <= '0;
      avail_q <= 1'b0;
      req_q <= 1'b0;
      word_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      tmo_q <= '0;
      hold_q <= '0;
    end else begin
      st_q <= st_d;
      ack_sr_q <= {ack_sr_q[1:0], DispAck};
      avail_q <= !fifo_empty;
      req_q <= req_d;
      word_q <= word_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
      hold_q <= hold_d;
    end
  end
  assign OUT_FULL = fifo_full;
  assign DispReq = req_q;
  assign DispAddr = word_q[ADDR_MSB:ADDR_LSB];
  assign DispFlag = word_q[FLAG_BIT];
  assign DispDigA = word_q[DIGA_MSB:DIGA_LSB];
  assign DispDigB = word_q[DIGB_MSB:DIGB_LSB];
  assign DispErr = err_q;
  assign DispOvf = ovf_q;
endmodule

// File: tb/tb_ng_out_dsky.sv
// tb_ng_out_dsky: directed vector table plus multi-cycle sequences for ng_out_dsky.
module tb_ng_out_dsky;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 64;
  localparam int HOLD_CYC = 8;
  logic CLK2, RST, OUT_WR, DispAck;
  logic [15:0] OUT_BUS;
  logic OUT_FULL, DispReq, DispFlag, DispErr, DispOvf;
  logic [3:0] DispAddr;
  logic [4:0] DispDigA, DispDigB;
  logic [18:0] obs;
  logic [14:0] data;
  typedef struct {
    logic rst;
    logic wr;
    logic ack;
    logic [15:0] bus;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [15:0] words [5];
  int checks = 0;
  int errors = 0;
  int n;
  ng_out_dsky #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HOLD_CYC(HOLD_CYC)) dut (
    .CLK2(CLK2), .RST(RST), .OUT_WR(OUT_WR), .OUT_BUS(OUT_BUS), .OUT_FULL(OUT_FULL),
    .DispReq(DispReq), .DispAck(DispAck), .DispAddr(DispAddr), .DispFlag(DispFlag),
    .DispDigA(DispDigA), .DispDigB(DispDigB), .DispErr(DispErr), .DispOvf(DispOvf)
  );
  assign obs = {DispReq, DispAddr, DispFlag, DispDigA, DispDigB, OUT_FULL, DispErr, DispOvf};
  assign data = {DispAddr, DispFlag, DispDigA, DispDigB};
  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;
  task automatic tick();
    @(negedge CLK2);
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic add(input logic r, input logic w, input logic a, input logic [15:0] bus,
                     input logic req, input logic [3:0] addr, input logic flag,
                     input logic [4:0] da, input logic [4:0] db);
    tbl.push_back('{r, w, a, bus, {req, addr, flag, da, db, 3'b000}});
  endtask
  task automatic reset_dut();
    OUT_WR = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    RST = 1'b0;
    OUT_WR = 1'b0;
    OUT_BUS = '0;
    DispAck = 1'b0;
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    add(1, 0, 0, 16'h0, 0, 4'h0, 0, 5'h00, 5'h00);
    add(0, 1, 0, 16'h5A53, 0, 4'h0, 0, 5'h00, 5'h00);
    add(0, 0, 0, 16'h0, 0, 4'h0, 0, 5'h00, 5'h00);
    add(0, 0, 0, 16'h0, 1, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 1, 16'h0, 1, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 1, 16'h0, 1, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 1, 16'h0, 0, 4'hB, 0, 5'h12, 5'h13);
    add(0, 1, 0, 16'h0C85, 0, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 0, 16'h0, 0, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 0, 16'h0, 0, 4'hB, 0, 5'h12, 5'h13);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 16'h0, 0, 4'hB, 0, 5'h12, 5'h13);
    add(0, 0, 0, 16'h0, 1, 4'h1, 1, 5'h04, 5'h05);
    add(0, 0, 1, 16'h0, 1, 4'h1, 1, 5'h04, 5'h05);
    add(0, 0, 1, 16'h0, 1, 4'h1, 1, 5'h04, 5'h05);
    add(0, 0, 1, 16'h0, 0, 4'h1, 1, 5'h04, 5'h05);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0, 0, 4'h1, 1, 5'h04, 5'h05);
    add(0, 1, 0, 16'h07FF, 0, 4'h1, 1, 5'h04, 5'h05);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 16'h0, 0, 4'h1, 1, 5'h04, 5'h05);
    add(0, 1, 0, 16'h07FF, 0, 4'h1, 1, 5'h04, 5'h05);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0, 0, 4'h1, 1, 5'h04, 5'h05);
    foreach (tbl[i]) begin
      RST = tbl[i].rst;
      OUT_WR = tbl[i].wr;
      OUT_BUS = tbl[i].bus;
      DispAck = tbl[i].ack;
      tick();
      chk($sformatf("row%0d", i), 32'(obs), 32'(tbl[i].exp));
    end
    OUT_WR = 1'b0;
    DispAck = 1'b0;
    reset_dut();
    OUT_WR = 1'b1;
    OUT_BUS = 16'h4A31;
    tick();
    OUT_BUS = 16'h7FFF;
    tick();
    OUT_WR = 1'b0;
    tick();
    chk("to_req_rise", 32'(DispReq), 32'd1);
    n = 0;
    while (DispReq && n < 200) begin
      tick();
      n++;
    end
    chk("to_len", n, TIMEOUT);
    chk("to_err", 32'(DispErr), 32'd1);
    n = 0;
    while (!DispReq && n < 50) begin
      tick();
      n++;
    end
    chk("to_gap", n, HOLD_CYC + 1);
    chk("to_next_data", 32'(data), 32'h7FFF);
    OUT_WR = 1'b1;
    OUT_BUS = 16'h1111;
    tick();
    OUT_BUS = 16'h2222;
    tick();
    OUT_WR = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_outs", 32'(obs), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DispReq) n++;
    end
    chk("rst_no_req", n, 0);
    reset_dut();
    OUT_WR = 1'b1;
    OUT_BUS = words[0];
    tick();
    OUT_WR = 1'b0;
    tick();
    tick();
    chk("full_first_req", 32'(DispReq), 32'd1);
    for (int i = 1; i < 5; i++) begin
      OUT_WR = 1'b1;
      OUT_BUS = words[i];
      tick();
    end
    chk("full_after_4", 32'(OUT_FULL), 32'd1);
    chk("ovf_before_5th", 32'(DispOvf), 32'd0);
    OUT_BUS = 16'h6666;
    tick();
    OUT_WR = 1'b0;
    chk("ovf_after_5th", 32'(DispOvf), 32'd1);
    chk("full_after_5th", 32'(OUT_FULL), 32'd1);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!DispReq && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("order_req%0d", i), 32'(DispReq), 32'd1);
      chk($sformatf("order_data%0d", i), 32'(data), 32'(words[i][14:0]));
      DispAck = 1'b1;
      n = 0;
      while (DispReq && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("order_ack%0d", i), 32'(DispReq), 32'd0);
      DispAck = 1'b0;
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (DispReq) n++;
    end
    chk("dropped_never_sent", n, 0);
    chk("no_err_in_order", 32'(DispErr), 32'd0);
    DispAck = 1'b1;
    reset_dut();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      OUT_WR = 1'b1;
      OUT_BUS = words[i];
      tick();
    end
    OUT_WR = 1'b0;
    chk("ackhi_full", 32'(OUT_FULL), 32'd1);
    chk("ackhi_no_req", 32'(DispReq), 32'd0);
    DispAck = 1'b0;
    tick();
    tick();
    OUT_WR = 1'b1;
    OUT_BUS = words[4];
    tick();
    OUT_WR = 1'b0;
    chk("pop_wr_req", 32'(DispReq), 32'd1);
    chk("pop_wr_ovf", 32'(DispOvf), 32'd1);
    chk("pop_wr_full", 32'(OUT_FULL), 32'd0);
    chk("pop_wr_data", 32'(data), 32'(words[0][14:0]));
    OUT_WR = 1'b1;
    OUT_BUS = 16'h6666;
    tick();
    OUT_WR = 1'b0;
    chk("pop_wr_refill", 32'(OUT_FULL), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
